// File: rtl/fetch_pkg.sv
// Shared constants and the IF/ID payload type for the LEGv8 fetch stage.
// Optional feature macro: FETCH_EARLY_BRANCH_EN (B/BL redirected inside fetch).
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W  = 64;
  localparam int unsigned INSTR_W       = 32;
  localparam logic [INSTR_W-1:0] FETCH_NOP_WORD = 32'hD503201F;

  // Primary opcodes of the unconditional immediate branches.
  localparam logic [5:0] OPC_B  = 6'b000101;
  localparam logic [5:0] OPC_BL = 6'b100101;

  // One IF/ID latch entry.
  typedef struct packed {
    logic [INSTR_W-1:0]      instr;
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_ADDR_W-1:0] pc4;
    logic                    valid;
    logic                    pred;
  } if_id_t;

  // True for B and BL, which carry a 26-bit word offset.
  function automatic logic is_uncond_branch(input logic [INSTR_W-1:0] word);
    return (word[31:26] == OPC_B) || (word[31:26] == OPC_BL);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline latch: reset/bubble beats hold, hold beats load.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_WORD = FETCH_NOP_WORD
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_bubble,
  input  logic   i_hold,
  input  if_id_t i_load_data,
  output if_id_t o_if_id
);

  if_id_t r_if_id;
  if_id_t w_bubble_data;

  // Bubble entry: the NOP encoding, never valid, never predicted.
  always_comb begin
    w_bubble_data       = '0;
    w_bubble_data.instr = NOP_WORD;
  end

  // Latch update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset || i_bubble) begin
      r_if_id <= w_bubble_data;
    end else if (!i_hold) begin
      r_if_id <= i_load_data;
    end
  end

  assign o_if_id = r_if_id;

endmodule

// File: rtl/instr_fetch_stage.sv
// LEGv8 fetch stage: PC register, next-PC selection and the IF/ID latch.
// Optional feature macro: FETCH_EARLY_BRANCH_EN (B/BL targets taken in fetch).
// The IF/ID payload type is sized by fetch_pkg::FETCH_ADDR_W; keep ADDR_W equal to it.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned         ADDR_W   = FETCH_ADDR_W,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0,
  parameter logic [INSTR_W-1:0]  NOP_WORD = FETCH_NOP_WORD
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_data,
  input  logic                stall,
  input  logic                flush,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic [INSTR_W-1:0]  instr_id,
  output logic [ADDR_W-1:0]   pc_id,
  output logic [ADDR_W-1:0]   pc4_id,
  output logic                valid_id,
  output logic                pred_id
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_next_pc;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic              w_bubble;
  logic              w_load;
  logic              w_early_take;
  if_id_t            w_load_data;
  if_id_t            w_if_id;

  assign imem_addr  = r_pc;
  assign w_pc_plus4 = r_pc + ADDR_W'(4);
  assign w_bubble   = flush | redirect;
  assign w_load     = ~(w_bubble | stall);

`ifdef FETCH_EARLY_BRANCH_EN
  logic [ADDR_W-1:0] w_br_target;

  // Word offset is sign-extended after the <<2 so negative targets wrap correctly.
  assign w_br_target  = r_pc + ADDR_W'($signed({imem_data[25:0], 2'b00}));
  assign w_early_take = w_load & is_uncond_branch(imem_data);
`else
  assign w_early_take = 1'b0;
`endif

  // Next-PC select: reset, redirect (ignores stall), stall hold, early branch, sequential.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (reset) begin
      w_next_pc = RESET_PC;
    end else if (redirect) begin
      w_next_pc = redirect_pc;
    end else if (stall) begin
      w_next_pc = r_pc;
`ifdef FETCH_EARLY_BRANCH_EN
    end else if (w_early_take) begin
      w_next_pc = w_br_target;
`endif
    end
  end

  // PC register.
  always_ff @(posedge clk) begin
    r_pc <= w_next_pc;
  end

  // Entry captured into IF/ID when neither bubbling nor holding.
  always_comb begin
    w_load_data       = '0;
    w_load_data.instr = imem_data;
    w_load_data.pc    = FETCH_ADDR_W'(r_pc);
    w_load_data.pc4   = FETCH_ADDR_W'(w_pc_plus4);
    w_load_data.valid = 1'b1;
    w_load_data.pred  = w_early_take;
  end

  if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id_reg (
    .clk         (clk),
    .reset       (reset),
    .i_bubble    (w_bubble),
    .i_hold      (stall),
    .i_load_data (w_load_data),
    .o_if_id     (w_if_id)
  );

  assign instr_id = w_if_id.instr;
  assign pc_id    = ADDR_W'(w_if_id.pc);
  assign pc4_id   = ADDR_W'(w_if_id.pc4);
  assign valid_id = w_if_id.valid;
  assign pred_id  = w_if_id.pred;

endmodule
